// File: rtl/game_flow_fsm.sv
// Game flow controller: title screen, play with lives, respawn delay,
// pause toggle and a game-over screen with an input lockout.
module game_flow_fsm #(
   parameter int         LIVES       = 3,
   parameter int         KEY_W       = 24,
   parameter logic [7:0] PAUSE_KEY   = 8'h29,
   parameter int         RESPAWN_CYC = 50_000_000,
   parameter int         GO_HOLD_CYC = 25_000_000
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         player_die,
   input  logic [KEY_W-1:0]             keycode,
   output logic                         start_screen,
   output logic                         game_screen,
   output logic                         game_over,
   output logic                         paused,
   output logic                         respawning,
   output logic [$clog2(LIVES+1)-1:0]   lives_left,
   output logic                         round_start
);

   // state    | meaning
   // S_START  | title screen, waiting for a fresh key press
   // S_PLAY   | game running
   // S_RESPAWN| player hit, waiting out the respawn interval
   // S_PAUSE  | game frozen until the pause key is pressed again
   // S_END    | game over; presses ignored until lockout expires

   localparam int NSLOT = KEY_W / 8;
   localparam int TMAX  = (RESPAWN_CYC > GO_HOLD_CYC) ? RESPAWN_CYC : GO_HOLD_CYC;
   localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int LW    = $clog2(LIVES + 1);

   localparam logic [TW-1:0] RESPAWN_LOAD = TW'(RESPAWN_CYC - 1);
   localparam logic [TW-1:0] GO_LOAD      = TW'(GO_HOLD_CYC - 1);
   localparam logic [LW-1:0] LIVES_INIT   = LW'(LIVES);
   localparam logic [LW-1:0] ONE_LIFE     = LW'(1);

   typedef enum logic [2:0] {
      S_START   = 3'd0,
      S_PLAY    = 3'd1,
      S_RESPAWN = 3'd2,
      S_PAUSE   = 3'd3,
      S_END     = 3'd4
   } state_t;

   state_t          state;
   logic [TW-1:0]   timer;
   logic            any_prev;
   logic            pause_prev;
   logic            any_now;
   logic            pause_now;
   logic            press;
   logic            pause_press;

   always_comb begin
      pause_now = 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
         if (keycode[i*8 +: 8] == PAUSE_KEY) pause_now = 1'b1;
      end
   end

   assign any_now     = (keycode != '0);
   assign press       = any_now & ~any_prev;
   assign pause_press = pause_now & ~pause_prev;

   // Edge detectors preset to 1 so a key held through reset needs a re-press.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= S_START;
         lives_left  <= '0;
         timer       <= '0;
         round_start <= 1'b0;
         any_prev    <= 1'b1;
         pause_prev  <= 1'b1;
      end else begin
         any_prev    <= any_now;
         pause_prev  <= pause_now;
         round_start <= 1'b0;
         case (state)
            S_START: begin
               if (press) begin
                  state       <= S_PLAY;
                  lives_left  <= LIVES_INIT;
                  round_start <= 1'b1;
               end
            end
            S_PLAY: begin
               if (player_die) begin
                  if (lives_left > ONE_LIFE) begin
                     state      <= S_RESPAWN;
                     lives_left <= lives_left - ONE_LIFE;
                     timer      <= RESPAWN_LOAD;
                  end else begin
                     state      <= S_END;
                     lives_left <= '0;
                     timer      <= GO_LOAD;
                  end
               end else if (pause_press) begin
                  state <= S_PAUSE;
               end
            end
            S_RESPAWN: begin
               if (timer == '0) state <= S_PLAY;
               else             timer <= timer - 1'b1;
            end
            S_PAUSE: begin
               if (pause_press) state <= S_PLAY;
            end
            S_END: begin
               if (timer != '0) timer <= timer - 1'b1;
               else if (press)  state <= S_START;
            end
            default: state <= S_START;
         endcase
      end
   end

   assign start_screen = (state == S_START);
   assign game_screen  = (state == S_PLAY) || (state == S_RESPAWN) || (state == S_PAUSE);
   assign game_over    = (state == S_END);
   assign paused       = (state == S_PAUSE);
   assign respawning   = (state == S_RESPAWN);

endmodule
